// File: rtl/alu_defs.sv
// Shared ALU definitions: operation codes and multiply sequencer types.
package alu_defs;

   localparam int unsigned ALU_CTRL_W   = 3;
   localparam int unsigned MUL_MAX_ITER = 32;

   // ALU operation codes decoded by the datapath ALU
   typedef enum logic [ALU_CTRL_W-1:0] {
      ARITH_ADD = 3'd0,
      ARITH_SUB = 3'd1,
      LOGIC_AND = 3'd2,
      LOGIC_ORR = 3'd3,
      LOGIC_EOR = 3'd4,
      MOV_      = 3'd5
   } alu_ctrl_t;

   // Multiply sequencer states
   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-and-add multiplier that borrows the shared ALU for its adds.
module alu_mul_seq
   import alu_defs::*;
#(
   parameter int unsigned WIDTH = MUL_MAX_ITER
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      op_a,
   input  logic [WIDTH-1:0]      op_b,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      product,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   output logic [ALU_CTRL_W-1:0] alu_ctrl,
   input  logic [WIDTH-1:0]      alu_result
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   mul_state_t       state, state_nxt;
   logic [WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0] mcand, mcand_nxt;
   logic [WIDTH-1:0] mplier, mplier_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             run_nxt;

   // Next-state and datapath update; the ALU result is only consumed in RUN
   always_comb begin
      state_nxt  = state;
      acc_nxt    = acc;
      mcand_nxt  = mcand;
      mplier_nxt = mplier;
      cnt_nxt    = cnt;

      case (state)
         MUL_IDLE, MUL_DONE: begin
            if (start) begin
               acc_nxt    = '0;
               mcand_nxt  = op_a;
               mplier_nxt = op_b;
               cnt_nxt    = '0;
               state_nxt  = (op_b == '0) ? MUL_DONE : MUL_RUN;
            end else begin
               state_nxt  = MUL_IDLE;
            end
         end
         MUL_RUN: begin
            if (mplier[0]) begin
               acc_nxt = alu_result;
            end
            mcand_nxt  = mcand << 1;
            mplier_nxt = mplier >> 1;
            cnt_nxt    = cnt + CNT_W'(1);
            // Stop once no multiplier bits remain; the count is a hard bound
            if (((mplier >> 1) == '0) || (cnt == CNT_W'(WIDTH - 1))) begin
               state_nxt = MUL_DONE;
            end
         end
         default: begin
            state_nxt = MUL_IDLE;
         end
      endcase
   end

   assign run_nxt = (state_nxt == MUL_RUN);

   // State, working registers and registered outputs derived from next values
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= MUL_IDLE;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         cnt      <= '0;
         product  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_ctrl <= MOV_;
      end else begin
         state    <= state_nxt;
         acc      <= acc_nxt;
         mcand    <= mcand_nxt;
         mplier   <= mplier_nxt;
         cnt      <= cnt_nxt;
         busy     <= run_nxt;
         done     <= (state_nxt == MUL_DONE);
         alu_a    <= run_nxt ? acc_nxt   : '0;
         alu_b    <= run_nxt ? mcand_nxt : '0;
         alu_ctrl <= run_nxt ? ARITH_ADD : MOV_;
         if (state_nxt == MUL_DONE) begin
            product <= acc_nxt;
         end
      end
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply controller for the single-cycle ARM core. It implements MUL (low WIDTH bits of Rn×Rm) by sequencing the shared ALU through shift-and-add iterations using the ARITH_ADD operation. It sits beside the ALU control decoder. While `busy` is high it drives the ALU operand and control inputs through the datapath's ALU input mux; the core stalls the PC on `busy`.

## Interface
- `WIDTH`, 32, operand/result width.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op_a`  in  WIDTH  multiplicand; sampled with `start`.
- `op_b`  in  WIDTH  multiplier; sampled with `start`.
- `busy`  out  1  high in RUN. The ALU input mux selects this block's outputs when `busy`=1.
- `done`  out  1  single-cycle pulse; `product` is valid.
- `product`  out  WIDTH  low WIDTH bits of op_a×op_b. Held until the next accepted `start`.
- `alu_a`  out  WIDTH  ALU operand A.
- `alu_b`  out  WIDTH  ALU operand B.
- `alu_ctrl`  out  3  ALU operation code.
- `alu_result`  in  WIDTH  ALU result, combinational from `alu_a`/`alu_b`/`alu_ctrl`.

## Operation
- **Registers:** `acc`, `mcand`, `mplier` (WIDTH each); iteration counter `cnt` ($clog2(WIDTH+1) bits); state.
- **IDLE:**
  - `start`=1 loads `acc`=0, `mcand`=op_a, `mplier`=op_b, `cnt`=0.
  - Next state is DONE if op_b==0, else RUN.
- **RUN (one bit per cycle):**
  - Drive `alu_ctrl`=ARITH_ADD, `alu_a`=acc, `alu_b`=mcand.
  - If `mplier[0]`=1, `acc`<=`alu_result`; otherwise `acc` holds.
  - `mcand`<=`mcand`<<1, discarding the MSB.
  - `mplier`<=`mplier`>>1, zero-filling.
  - `cnt`<=`cnt`+1.
- **RUN exit:** go to DONE when (`mplier`>>1)==0 or `cnt`==WIDTH-1. This is early termination on the multiplier MSB; the bound of WIDTH iterations is a hard guard.
- **DONE:**
  - `done`=1 and `product`=`acc` for exactly one cycle.
  - `start`=1 in DONE is accepted like IDLE, allowing back-to-back operations.
  - Otherwise the next state is IDLE.
- **ALU drive outside RUN:** `alu_ctrl`=MOV_, `alu_a`=`alu_b`=0.
- **Arithmetic:** modulo 2^WIDTH, unsigned. The low WIDTH bits are identical for signed operands, as ARM MUL requires. No flags are produced.
- **Ignored start:** `start` in RUN is ignored and has no effect on registers.
- **Reset:**
  - `rst_n` low at any time, including mid-RUN, immediately forces state IDLE and clears `acc`, `mcand`, `mplier`, `cnt`, and `product` to 0.
  - Outputs go to `busy`=0, `done`=0, `alu_ctrl`=MOV_, `alu_a`=`alu_b`=0.
  - No operation resumes after reset release.

## Timing
- Cycle 0 is the cycle in which `start` is sampled high.
- Let k = index of the MSB set in op_b, plus 1 (k=0 when op_b==0).
- `busy` is high in cycles 1..k.
- `done` is high in cycle k+1.
- Latency is k+1 cycles; the worst case is WIDTH+1.
- `product` updates at the edge ending cycle k and is stable from cycle k+1 onward.
- `busy` and `done` are never high together.
- ALU path: one full combinational ALU evaluation per RUN cycle, registered into `acc`. This block adds no extra stage.

## Structure
- In the shared `alu_defs` package:
  - typedef enum `mul_state_t` {MUL_IDLE, MUL_RUN, MUL_DONE}.
  - Constant `MUL_MAX_ITER` = WIDTH default (32).
- This block reuses ARITH_ADD and MOV_ from the same package.
- Single module; no sub-module is needed. The ALU instance stays in the datapath and is only muxed.

## Test plan
- **Basic multiply:** op_a=6, op_b=7, start pulse → busy in cycles 1-3, done in cycle 4, product=42. `alu_ctrl`=ARITH_ADD during busy and MOV_ otherwise.
- **Zero multiplier:** op_a=0xDEADBEEF, op_b=0 → busy never asserts, done in cycle 1, product=0.
- **Worst case with wrap:** op_a=op_b=0xFFFFFFFF → busy for 32 cycles, done in cycle 33, product=0x00000001. Separately, 0x80000000×2 → product=0.
- **Start handling:**
  - 3×5 then `start` with 9×9 during busy → the second request is ignored; product=15.
  - A new `start` (4×4) held high in the DONE cycle is accepted; the next product=16 with no IDLE cycle between.
- **Reset mid-operation:** op_a=0x1234, op_b=0xFFFF, `rst_n` low in cycle 5 → immediately busy=0, done=0, product=0, `alu_ctrl`=MOV_. After release, no done pulse appears without a new `start`.
- **Random check:** 1000 random pairs → product==(op_a*op_b)[WIDTH-1:0], and latency==k+1 for every pair.
